// File: rtl/econet_pkg.sv
// rtl/econet_pkg.sv - shared Econet TX queue types, FCS constants and status bit positions
// Contents: tx_state_e framing states, HDLC FCS (CRC-16/CCITT, LSB-first) constants and
//   byte-update function, sys_status bit positions.
package econet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RXWAIT,
        ST_HOLDOFF,
        ST_TX_START,
        ST_TX,
        ST_FCS_1,
        ST_FCS_2,
        ST_TX_END
    } tx_state_e;

    // Bit-reversed 0x1021: bytes go onto the line LSB first, so the register shifts right.
    localparam logic [15:0] FCS_POLY = 16'h8408;
    localparam logic [15:0] FCS_INIT = 16'hFFFF;

    localparam int STAT_BUSY     = 8;
    localparam int STAT_FULL     = 9;
    localparam int STAT_OVF      = 10;
    localparam int STAT_DONE_LSB = 16;

    function automatic logic [15:0] fcs_update(input logic [15:0] fcs, input logic [7:0] data);
        logic [15:0] c;
        c = fcs ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ FCS_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/econet_tx_queue_if.sv
// rtl/econet_tx_queue_if.sv - CPU bus and serialiser handshake bundle for econet_tx_queue
// Signals: sys_select/sys_we/sys_addr/sys_data/sys_select_desc (CPU writes), sys_status (CPU read),
//   receiving/tx_abort/request_byte (serialiser to queue), tx_byte/start_frame/end_frame (queue to serialiser).
// Modports: master = CPU + serialiser side, slave = econet_tx_queue.
interface econet_tx_queue_if #(
    parameter int ADDR_W = 10
);
    logic              sys_select;
    logic [3:0]        sys_we;
    logic [ADDR_W-3:0] sys_addr;
    logic [31:0]       sys_data;
    logic              sys_select_desc;
    logic [31:0]       sys_status;
    logic              receiving;
    logic              tx_abort;
    logic              request_byte;
    logic [7:0]        tx_byte;
    logic              start_frame;
    logic              end_frame;

    modport master (
        output sys_select, sys_we, sys_addr, sys_data, sys_select_desc,
        output receiving, tx_abort, request_byte,
        input  sys_status, tx_byte, start_frame, end_frame
    );

    modport slave (
        input  sys_select, sys_we, sys_addr, sys_data, sys_select_desc,
        input  receiving, tx_abort, request_byte,
        output sys_status, tx_byte, start_frame, end_frame
    );
endinterface

// File: rtl/econet_desc_fifo.sv
// rtl/econet_desc_fifo.sv - frame descriptor queue (DEPTH entries of DATA_W bits)
// Ports: clk, resetn (sync active-low), push/push_data, pop, head (oldest entry),
//   count, full, empty, push_dropped (push refused because full with no pop).
module econet_desc_fifo #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int DATA_W = 20
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              empty,
    output logic              push_dropped
);
    localparam logic [PTR_W:0] FULL_CNT = {1'b1, {PTR_W{1'b0}}};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic              do_push, do_pop;

    always_comb begin
        full    = (cnt_q == FULL_CNT);
        empty   = (cnt_q == '0);
        do_pop  = pop && !empty;
        // A pop in the same cycle frees a slot, so a push into a full queue still lands.
        do_push = push && (!full || do_pop);
        push_dropped = push && !do_push;
        wr_d  = do_push ? wr_q + 1'b1 : wr_q;
        rd_d  = do_pop  ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        head  = mem[rd_q];
        count = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/econet_tx_queue.sv
// rtl/econet_tx_queue.sv - Econet transmit queue: frame RAM, descriptor queue, framing FSM with FCS
// Ports: sys_clk, reset_n (sync active-low), bus (econet_tx_queue_if.slave: CPU RAM/descriptor
//   writes and sys_status, serialiser tx_byte/request_byte/start_frame/end_frame/tx_abort/receiving),
//   busy, frame_done, frame_err.
// Build option: ECO_TX_RETRY_EN - an aborted frame is resent up to MAX_RETRY times before dropping.
module econet_tx_queue
    import econet_pkg::*;
#(
    parameter int BUF_BYTES  = 1024,
    parameter int ADDR_W     = 10,
    parameter int DESC_DEPTH = 4,
    parameter int DESC_W     = 2,
    parameter int HOLDOFF    = 64,
    parameter int MAX_RETRY  = 3
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    econet_tx_queue_if.slave bus,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_err
);
    localparam int WORDS   = BUF_BYTES / 4;
    localparam int HOLD_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);
`ifdef ECO_TX_RETRY_EN
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
`else
    // With a limit of zero the first abort already drops the frame.
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = '0;
`endif

    tx_state_e           state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [15:0]         fcs_q, fcs_d;
    logic [15:0]         frames_done_q, frames_done_d;
    logic                overflow_q, overflow_d;
    logic                frame_done_q, frame_done_d;
    logic                frame_err_q, frame_err_d;
    logic                receiving_q;
    logic [1:0]          lane_q;
    logic [31:0]         rd_word_q;
    logic [31:0]         ram [WORDS];

    logic                push, pop, push_dropped, fifo_full, fifo_empty, in_frame;
    logic [2*ADDR_W-1:0] head, push_data;
    logic [DESC_W:0]     fifo_count;
    logic [ADDR_W-1:0]   head_start, head_end;
    logic [7:0]          tx_data_byte;
    logic [31:0]         status;

    assign push       = bus.sys_select_desc && (bus.sys_we != 4'h0);
    assign push_data  = {bus.sys_data[ADDR_W+15:16], bus.sys_data[ADDR_W-1:0]};
    assign head_start = head[ADDR_W-1:0];
    assign head_end   = head[2*ADDR_W-1:ADDR_W];

    econet_desc_fifo #(
        .DEPTH (DESC_DEPTH),
        .PTR_W (DESC_W),
        .DATA_W(2 * ADDR_W)
    ) u_desc_fifo (
        .clk         (sys_clk),
        .resetn      (reset_n),
        .push        (push),
        .push_data   (push_data),
        .pop         (pop),
        .head        (head),
        .count       (fifo_count),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .push_dropped(push_dropped)
    );

    // Frame RAM survives reset. The read port follows ptr_q one cycle late; the
    // serialiser's request spacing of at least two cycles hides that latency.
    always_ff @(posedge sys_clk) begin
        if (bus.sys_select) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.sys_we[b]) begin
                    ram[bus.sys_addr][8*b +: 8] <= bus.sys_data[8*b +: 8];
                end
            end
        end
        rd_word_q <= ram[ptr_q[ADDR_W-1:2]];
    end

    assign tx_data_byte = rd_word_q[{lane_q, 3'b000} +: 8];
    assign in_frame = (state_q == ST_TX) || (state_q == ST_FCS_1) ||
                      (state_q == ST_FCS_2) || (state_q == ST_TX_END);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        hold_d       = hold_q;
        retry_d      = retry_q;
        fcs_d        = fcs_q;
        pop          = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                fcs_d = FCS_INIT;
                if (!fifo_empty) state_d = ST_RXWAIT;
            end
            ST_RXWAIT: begin
                fcs_d = FCS_INIT;
                if (!receiving_q) begin
                    state_d = ST_HOLDOFF;
                    hold_d  = '0;
                end
            end
            ST_HOLDOFF: begin
                if (receiving_q) begin
                    state_d = ST_RXWAIT;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = ST_TX_START;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_TX_START: begin
                ptr_d   = head_start;
                state_d = ST_TX;
            end
            ST_TX: begin
                if (bus.request_byte) begin
                    fcs_d = fcs_update(fcs_q, tx_data_byte);
                    // end < start needs no special case: ptr wraps mod BUF_BYTES.
                    if (ptr_q == head_end) state_d = ST_FCS_1;
                    else                   ptr_d   = ptr_q + 1'b1;
                end
            end
            ST_FCS_1: if (bus.request_byte) state_d = ST_FCS_2;
            ST_FCS_2: if (bus.request_byte) state_d = ST_TX_END;
            ST_TX_END: begin
                if (bus.request_byte) begin
                    state_d      = ST_IDLE;
                    pop          = 1'b1;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over a simultaneous byte request.
        if (in_frame && bus.tx_abort) begin
            fcs_d        = FCS_INIT;
            frame_done_d = 1'b0;
            if (retry_q == RETRY_LIMIT) begin
                state_d     = ST_IDLE;
                pop         = 1'b1;
                frame_err_d = 1'b1;
            end else begin
                state_d = ST_RXWAIT;
                pop     = 1'b0;
                retry_d = retry_q + 1'b1;
            end
        end
        if (pop) retry_d = '0;

        frames_done_d = frame_done_d ? frames_done_q + 16'd1 : frames_done_q;
        overflow_d    = overflow_q || push_dropped;
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            hold_q        <= '0;
            retry_q       <= '0;
            fcs_q         <= FCS_INIT;
            frames_done_q <= '0;
            overflow_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            receiving_q   <= 1'b0;
            lane_q        <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_q        <= hold_d;
            retry_q       <= retry_d;
            fcs_q         <= fcs_d;
            frames_done_q <= frames_done_d;
            overflow_q    <= overflow_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
            // One register stage on the line-receiver flag before it gates a frame start.
            receiving_q   <= bus.receiving;
            lane_q        <= ptr_q[1:0];
        end
    end

    always_comb begin
        case (state_q)
            ST_TX:    bus.tx_byte = tx_data_byte;
            ST_FCS_1: bus.tx_byte = ~fcs_q[7:0];
            ST_FCS_2: bus.tx_byte = ~fcs_q[15:8];
            default:  bus.tx_byte = 8'h00;
        endcase
    end

    always_comb begin
        status                    = '0;
        status[DESC_W:0]          = fifo_count;
        status[STAT_BUSY]         = busy;
        status[STAT_FULL]         = fifo_full;
        status[STAT_OVF]          = overflow_q;
        status[STAT_DONE_LSB +: 16] = frames_done_q;
    end

    assign busy            = (state_q != ST_IDLE) || !fifo_empty;
    assign frame_done      = frame_done_q;
    assign frame_err       = frame_err_q;
    assign bus.start_frame = (state_q == ST_TX_START);
    assign bus.end_frame   = (state_q == ST_TX_END);
    assign bus.sys_status  = status;
endmodule
